// File: rtl/rs485_pkg.sv
// Shared types and helpers for the RS485 echo node.
// The RS485_PARITY_EN macro adds an even-parity bit to both FSMs.
package rs485_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef RS485_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LEAD,
        TX_START,
        TX_DATA,
`ifdef RS485_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP,
        TX_GUARD
    } tx_state_e;

    function automatic int calc_bit_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Parity bit that makes the total count of ones even.
    function automatic logic even_par(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rs485_fifo.sv
// Frame buffer for the echo node: registered pointers, first-word-fall-through read.
module rs485_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [DATA_BITS-1:0]          wdata_i,
    input  logic                          pop_i,
    output logic [DATA_BITS-1:0]          rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_q, rd_q;
    logic                 do_push, do_pop;

    assign level_o = wr_q - rd_q;
    assign full_o  = (level_o == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so push-while-full succeeds then.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rs485_echo_buf.sv
// Half-duplex RS485 echo node: receive, buffer, retransmit when the bus is free.
// Optional even parity on both paths via RS485_PARITY_EN.
module rs485_echo_buf import rs485_pkg::*; #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int GUARD_BITS = 1
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        rx,
    output logic                        tx,
    output logic                        work_en,
    output logic                        rx_frame_err,
    output logic                        fifo_ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, UART_BPS);
    localparam int CW      = cnt_width(BIT_CNT);
    localparam int IW      = cnt_width((DATA_BITS > GUARD_BITS ? DATA_BITS : GUARD_BITS) + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(BIT_CNT / 2 - 1);
    localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] GUARD_LAST = IW'(GUARD_BITS - 1);

    logic rx_s1_q, rx_s2_q, rx_p_q, rx_fall;

    rx_state_e            rx_st_q, rx_st_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_err_q, rx_err_d, rx_push, rx_tick;

    tx_state_e            tx_st_q, tx_st_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d, tx_q, tx_d, we_q, we_d;
    logic                 tx_pop, tx_tick, tx_go;

    logic [DATA_BITS-1:0] f_rdata;
    logic                 f_full, f_empty, ovf_q;

    assign rx_fall = rx_p_q & ~rx_s2_q;
    assign rx_tick = (rx_cnt_q == CNT_LAST);
    assign tx_tick = (tx_cnt_q == CNT_LAST);
    // Skip the cycle a start edge is seen so TX never grabs the bus mid-arrival.
    assign tx_go   = ~f_empty & (rx_st_q == RX_IDLE) & ~rx_fall;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
        rx_idx_d = rx_idx_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        rx_err_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                rx_idx_d = rx_idx_q + 1'b1;
`ifdef RS485_PARITY_EN
                if (rx_idx_q == DATA_LAST) rx_st_d = RX_PARITY;
            end
            RX_PARITY: if (rx_tick) begin
                if (rx_s2_q != even_par(9'(rx_sh_q))) begin
                    rx_err_d = 1'b1;
                    rx_st_d  = RX_IDLE;
                end else begin
                    rx_st_d  = RX_STOP;
                end
`else
                if (rx_idx_q == DATA_LAST) rx_st_d = RX_STOP;
`endif
            end
            RX_STOP: if (rx_tick) begin
                rx_push  = rx_s2_q;
                rx_err_d = ~rx_s2_q;
                rx_st_d  = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
        // Our own echo comes back on rx while driving; ignore it.
        if (we_q) rx_st_d = RX_IDLE;
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        tx_idx_d = tx_idx_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_pop   = 1'b0;
        case (tx_st_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_go) tx_st_d = TX_LEAD;
            end
            TX_LEAD: if (tx_tick) begin
                tx_pop   = 1'b1;
                tx_sh_d  = f_rdata;
                tx_par_d = even_par(9'(f_rdata));
                tx_st_d  = TX_START;
            end
            TX_START: if (tx_tick) begin
                tx_idx_d = '0;
                tx_st_d  = TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_idx_d = tx_idx_q + 1'b1;
`ifdef RS485_PARITY_EN
                if (tx_idx_q == DATA_LAST) tx_st_d = TX_PARITY;
            end
            TX_PARITY: if (tx_tick) begin
                tx_st_d = TX_STOP;
`else
                if (tx_idx_q == DATA_LAST) tx_st_d = TX_STOP;
`endif
            end
            TX_STOP: if (tx_tick) begin
                tx_idx_d = '0;
                if (!f_empty) begin
                    tx_pop   = 1'b1;
                    tx_sh_d  = f_rdata;
                    tx_par_d = even_par(9'(f_rdata));
                    tx_st_d  = TX_START;
                end else begin
                    tx_st_d  = TX_GUARD;
                end
            end
            TX_GUARD: if (tx_tick) begin
                tx_idx_d = tx_idx_q + 1'b1;
                if (tx_idx_q == GUARD_LAST) tx_st_d = TX_IDLE;
            end
            default: tx_st_d = TX_IDLE;
        endcase
        // Line level and driver enable are registered from the next state.
        case (tx_st_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_sh_d[0];
`ifdef RS485_PARITY_EN
            TX_PARITY: tx_d = tx_par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        we_d = (tx_st_d != TX_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_p_q   <= 1'b1;
            rx_st_q  <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            rx_sh_q  <= '0;
            rx_err_q <= 1'b0;
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_idx_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            tx_q     <= 1'b1;
            we_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rx_s1_q  <= rx;
            rx_s2_q  <= rx_s1_q;
            rx_p_q   <= rx_s2_q;
            rx_st_q  <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_idx_q <= rx_idx_d;
            rx_sh_q  <= rx_sh_d;
            rx_err_q <= rx_err_d;
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_idx_q <= tx_idx_d;
            tx_sh_q  <= tx_sh_d;
            tx_par_q <= tx_par_d;
            tx_q     <= tx_d;
            we_q     <= we_d;
            ovf_q    <= rx_push & f_full & ~tx_pop;
        end
    end

    rs485_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (rx_push),
        .wdata_i (rx_sh_q),
        .pop_i   (tx_pop),
        .rdata_o (f_rdata),
        .full_o  (f_full),
        .empty_o (f_empty),
        .level_o (fifo_level)
    );

    assign tx           = tx_q;
    assign work_en      = we_q;
    assign rx_frame_err = rx_err_q;
    assign fifo_ovf     = ovf_q;

endmodule

// File: tb/tb_rs485_echo_buf.sv
// Scoreboard bench for rs485_echo_buf: frames driven on rx are expected back on tx.
module tb_rs485_echo_buf;
    localparam int BIT = 10;

    logic       sys_clk = 1'b0, sys_rst_n = 1'b0, rx = 1'b1;
    logic       tx, work_en, rx_frame_err, fifo_ovf;
    logic [2:0] fifo_level;

    int n_cmp = 0, n_bad = 0;
    int win_cnt = 0, frames_seen = 0, aborted = 0, err_cnt = 0, ovf_cnt = 0;
    logic [7:0] exp_q [$];

    rs485_echo_buf #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
        .FIFO_DEPTH(4), .GUARD_BITS(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx), .tx(tx),
        .work_en(work_en), .rx_frame_err(rx_frame_err),
        .fifo_ovf(fifo_ovf), .fifo_level(fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        cyc(n);
    endtask

    // stop_len < BIT shortens the stop bit so the next start edge lands
    // on the first idle cycle of the receiver, keeping TX off the bus.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef RS485_PARITY_EN
        hold(^d, BIT);
`endif
        hold(stop_v, stop_len);
        if (!stop_v) hold(1'b1, 2 * BIT);
    endtask

    task automatic wait_bits(input int n, inout bit ok);
        repeat (n) begin
            @(negedge sys_clk);
            if (!work_en) ok = 1'b0;
        end
    endtask

    always @(negedge sys_clk) begin
        if (rx_frame_err) err_cnt++;
        if (fifo_ovf)     ovf_cnt++;
    end

    // tx monitor: decodes each work_en window and checks its timing.
    initial begin : mon
        int n;
        bit ok, in_win, st, sp;
        logic [7:0] d;
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            if (work_en) begin
                n = 0;
                while (tx && work_en && n < 40) begin @(negedge sys_clk); n++; end
                chk("lead_len", n, BIT);
                win_cnt++;
                in_win = 1'b1;
                while (in_win) begin
                    ok = 1'b1;
                    d  = '0;
                    wait_bits(BIT / 2, ok);
                    st = tx;
                    for (int i = 0; i < 8; i++) begin
                        wait_bits(BIT, ok);
                        d[i] = tx;
                    end
`ifdef RS485_PARITY_EN
                    wait_bits(BIT, ok);
                    if (ok) chk("tx_parity", int'(tx), int'(^d));
`endif
                    wait_bits(BIT, ok);
                    sp = tx;
                    if (!ok) begin
                        aborted++;
                        in_win = 1'b0;
                    end else begin
                        chk("tx_start", int'(st), 0);
                        chk("tx_stop", int'(sp), 1);
                        if (exp_q.size() == 0) begin
                            chk("sb_empty", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("tx_data", int'(d), int'(e));
                        end
                        frames_seen++;
                        n = 0;
                        while (tx && work_en && n < 60) begin @(negedge sys_clk); n++; end
                        if (!tx && work_en) begin
                            chk("b2b_gap", n, BIT / 2);
                        end else if (!work_en) begin
                            chk("guard_len", n - BIT / 2, 2 * BIT);
                            in_win = 1'b0;
                        end else begin
                            chk("win_timeout", n, 0);
                            in_win = 1'b0;
                        end
                    end
                end
                n = 0;
                while (work_en && n < 200) begin @(negedge sys_clk); n++; end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0, e0, o0, a0, n;
        cyc(3);
        chk("rst_tx", int'(tx), 1);
        chk("rst_we", int'(work_en), 0);
        chk("rst_err", int'(rx_frame_err), 0);
        chk("rst_ovf", int'(fifo_ovf), 0);
        chk("rst_lvl", int'(fifo_level), 0);
        sys_rst_n = 1'b1;
        cyc(20);

        // single frame
        w0 = win_cnt; f0 = frames_seen;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, BIT);
        chk("t1_lvl_buf", int'(fifo_level), 1);
        cyc(250);
        chk("t1_win", win_cnt - w0, 1);
        chk("t1_frames", frames_seen - f0, 1);
        chk("t1_lvl", int'(fifo_level), 0);

        // burst: one window, contiguous frames
        w0 = win_cnt; f0 = frames_seen;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, (i == 3) ? BIT : 6);
        end
        cyc(450);
        chk("t2_win", win_cnt - w0, 1);
        chk("t2_frames", frames_seen - f0, 3);
        chk("t2_lvl", int'(fifo_level), 0);

        // overflow: 6 frames into a 4-deep buffer
        w0 = win_cnt; f0 = frames_seen; o0 = ovf_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1, (i == 5) ? BIT : 6);
        end
        chk("t3_lvl_full", int'(fifo_level), 4);
        chk("t3_ovf", ovf_cnt - o0, 2);
        cyc(600);
        chk("t3_win", win_cnt - w0, 1);
        chk("t3_frames", frames_seen - f0, 4);
        chk("t3_lvl", int'(fifo_level), 0);

        // frame error
        w0 = win_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, BIT);
        chk("t4_lvl_now", int'(fifo_level), 0);
        cyc(200);
        chk("t4_err", err_cnt - e0, 1);
        chk("t4_lvl", int'(fifo_level), 0);
        chk("t4_win", win_cnt - w0, 0);

        // short glitch
        w0 = win_cnt; e0 = err_cnt;
        hold(1'b0, 3);
        hold(1'b1, 150);
        chk("t5_err", err_cnt - e0, 0);
        chk("t5_lvl", int'(fifo_level), 0);
        chk("t5_win", win_cnt - w0, 0);

        // rx activity while driving is ignored
        w0 = win_cnt; f0 = frames_seen; e0 = err_cnt;
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, BIT);
        n = 0;
        while (!work_en && n < 50) begin cyc(1); n++; end
        chk("t6_we_up", int'(work_en), 1);
        for (int i = 0; i < 60; i++) hold(1'($urandom_range(0, 1)), 1);
        rx = 1'b1;
        chk("t6_lvl_busy", int'(fifo_level), 0);
        cyc(250);
        chk("t6_win", win_cnt - w0, 1);
        chk("t6_frames", frames_seen - f0, 1);
        chk("t6_err", err_cnt - e0, 0);
        chk("t6_lvl", int'(fifo_level), 0);

        // reset during data bit 4
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, BIT);
        n = 0;
        while (!(work_en && !tx) && n < 60) begin cyc(1); n++; end
        chk("t7_start_seen", int'(work_en && !tx), 1);
        a0 = aborted;
        cyc(BIT + 4 * BIT + 3);
        sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_tx", int'(tx), 1);
        chk("t7_rst_we", int'(work_en), 0);
        exp_q.delete();
        cyc(3);
        sys_rst_n = 1'b1;
        w0 = win_cnt; f0 = frames_seen;
        cyc(300);
        chk("t7_abort", aborted - a0, 1);
        chk("t7_lvl", int'(fifo_level), 0);
        chk("t7_win", win_cnt - w0, 0);
        chk("t7_frames", frames_seen - f0, 0);

        chk("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
